wb_stage_n: RTL and testbench
=============================

Name: wb_stage_n

Overview:
- Parametrised N-lane writeback stage with a real valid/ready handshake; successor to the fixed dual-issue EX2/WB register.
- Accepts one issue bundle per handshake from EX2 and holds it until every long-latency result for it has arrived.
- Long-latency sources are the shared divider, dcache and CSR unit.
- Commits register writes, debug/commit info and at most one precise exception (oldest lane) per bundle.

Parameters:
LANES, 2, number of issue lanes in a bundle (1..4)
DW, 32, data/PC width
RW, 5, register index width
EW, 7, exception code width

Ports:
clk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
flush_in  in  1  synchronous squash from later/external logic
in_valid  in  1  bundle valid
in_ready  out  1  stage can accept bundle
in_lane_v  in  LANES  per-lane instruction valid
in_pc  in  LANES*DW  per-lane PC
in_rd  in  LANES*RW  per-lane destination
in_we  in  LANES  per-lane writes register
in_src  in  LANES*2  result source: 0 ALU, 1 DIV, 2 MEM load, 3 CSR
in_alu_data  in  LANES*DW  ALU/mul/branch-link result
in_exc  in  LANES  lane raised exception
in_ecode  in  LANES*EW  lane exception code
in_badv  in  LANES*DW  lane faulting address
interrupt  in  1  pending interrupt, sampled at acceptance
div_ready, div_data  in  1, DW  shared divider result strobe
dcache_ready, dcache_data  in  1, DW  load data strobe
csr_ready, csr_data  in  1, DW  CSR read data strobe
wb_valid  out  LANES  lane committed this cycle
wb_we  out  LANES  register write enable
wb_rd  out  LANES*RW  write index
wb_data  out  LANES*DW  write data
wb_pc  out  LANES*DW  committed PC (debug)
exc_valid  out  1  exception/interrupt commit pulse; also flush_out
exc_ecode  out  EW  exception code
exc_era  out  DW  PC of excepting lane
exc_badv  out  DW  bad address
exc_badv_we  out  1  badv/vppn must be written (PIL, PIS, PIF, PME, PPI, ADEF, ALE, TLBR)
exc_tlbr  out  1  ecode is TLBR (select TLB refill entry)

Behaviour:
- Reset (aresetn low, async): state IDLE, all outputs and pending bits 0, in_ready 0 while in reset.
- States: IDLE, WAIT.
- in_ready = (state==IDLE) & ~flush_in. Accept = in_valid & in_ready.
- Exception lane k = lowest-index lane with in_lane_v & in_exc.
  - Lanes < k proceed normally; lanes >= k are squashed (wb_valid/wb_we 0, never pending).
  - If interrupt=1 at accept, interrupt wins: k=0, ecode 0x00, all lanes squashed, badv_we 0.
- On accept, pending[i] = surviving lane & in_we & src!=ALU.
  - No pending: outputs registered next cycle (latency 1, throughput 1/cycle), stay IDLE.
  - Otherwise go to WAIT; ALU data latched.
- In WAIT, each strobe completes the lowest-index pending lane of its source; data is latched and the pending bit cleared.
  - div, dcache and csr strobes may complete different lanes in the same cycle.
  - Strobes with no matching pending lane are ignored.
- When the last pending bit clears at cycle t, the commit outputs appear at t+1 and state returns to IDLE at t+1.
- Commit outputs are single-cycle pulses; all are 0 on non-commit cycles. wb_we[i] = wb_valid[i] & in_we[i].
- exc_valid pulses with the bundle's commit, never before lanes < k commit. exc_era = pc[k].
- flush_in (sync, highest priority): clears pending, state→IDLE, suppresses any commit due next cycle, blocks accept that cycle.
- A bundle with no valid lanes is accepted and produces no outputs.

Test Plan:
- LANES=2, ALU bundle pc 0x1C000000/0x1C000004, rd 3/4, data 0xAA/0xBB -> next cycle wb_valid=2'b11, wb_data 0xAA/0xBB; back-to-back bundles commit every cycle.
- Lane0 DIV, lane1 ALU; div_ready with div_data 0x7 five cycles later -> in_ready 0 throughout; both lanes commit together one cycle after div_ready, wb_data 0x7/ALU value.
- Both lanes MEM loads; two dcache_ready strobes with 0x11 then 0x22 -> lane0=0x11, lane1=0x22, commit after second strobe.
- Lane1 in_exc, ecode ALE, badv 0x1003 -> lane0 commits; lane1 wb_valid 0; exc_valid=1, exc_era=pc1, exc_badv_we=1, exc_tlbr=0.
- interrupt=1 at accept with ALU bundle -> wb_valid 0, exc_valid=1, ecode 0, exc_era=pc0.
- flush_in during WAIT then div_ready -> no commit; in_ready returns to 1 the cycle after flush. Reset asserted mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_n.sv
// N-lane writeback stage: holds one issue bundle until its long-latency results
// arrive, then commits the surviving lanes and at most one precise exception.
module wb_stage_n #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int EW    = 7
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                flush_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES-1:0]    in_lane_v,
    input  logic [LANES*DW-1:0] in_pc,
    input  logic [LANES*RW-1:0] in_rd,
    input  logic [LANES-1:0]    in_we,
    input  logic [LANES*2-1:0]  in_src,
    input  logic [LANES*DW-1:0] in_alu_data,
    input  logic [LANES-1:0]    in_exc,
    input  logic [LANES*EW-1:0] in_ecode,
    input  logic [LANES*DW-1:0] in_badv,
    input  logic                interrupt,
    input  logic                div_ready,
    input  logic [DW-1:0]       div_data,
    input  logic                dcache_ready,
    input  logic [DW-1:0]       dcache_data,
    input  logic                csr_ready,
    input  logic [DW-1:0]       csr_data,
    output logic [LANES-1:0]    wb_valid,
    output logic [LANES-1:0]    wb_we,
    output logic [LANES*RW-1:0] wb_rd,
    output logic [LANES*DW-1:0] wb_data,
    output logic [LANES*DW-1:0] wb_pc,
    output logic                exc_valid,
    output logic [EW-1:0]       exc_ecode,
    output logic [DW-1:0]       exc_era,
    output logic [DW-1:0]       exc_badv,
    output logic                exc_badv_we,
    output logic                exc_tlbr
);
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_DIV = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;
    localparam logic [1:0] SRC_CSR = 2'd3;

    localparam logic [EW-1:0] EC_PIL  = EW'(32'h01);
    localparam logic [EW-1:0] EC_PIS  = EW'(32'h02);
    localparam logic [EW-1:0] EC_PIF  = EW'(32'h03);
    localparam logic [EW-1:0] EC_PME  = EW'(32'h04);
    localparam logic [EW-1:0] EC_PPI  = EW'(32'h07);
    localparam logic [EW-1:0] EC_ADE  = EW'(32'h08);
    localparam logic [EW-1:0] EC_ALE  = EW'(32'h09);
    localparam logic [EW-1:0] EC_TLBR = EW'(32'h3F);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                accept, commit_q, commit_d;
    logic [LANES-1:0]    pend_q, pend_d, pend_new, surv, clr;
    logic [LANES-1:0]    lane_ok_q, we_q;
    logic [LANES*2-1:0]  src_q;
    logic [LANES*RW-1:0] rd_q;
    logic [LANES*DW-1:0] pc_q, data_q;
    logic                exc_any, div_hit, mem_hit, csr_hit;
    logic [EW-1:0]       k_ecode, ecode_q;
    logic [DW-1:0]       k_pc, k_badv, era_q, badv_q;
    logic                exc_q, badv_we_q, tlbr_q;

    function automatic logic needs_badv(input logic [EW-1:0] ec);
        return ec == EC_PIL || ec == EC_PIS || ec == EC_PIF || ec == EC_PME ||
               ec == EC_PPI || ec == EC_ADE || ec == EC_ALE || ec == EC_TLBR;
    endfunction

    // The oldest excepting lane and every younger lane are squashed.
    always_comb begin
        exc_any  = 1'b0;
        k_ecode  = '0;
        k_pc     = in_pc[DW-1:0];
        k_badv   = '0;
        surv     = '0;
        pend_new = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_v[i] && in_exc[i] && !exc_any) begin
                exc_any = 1'b1;
                k_ecode = in_ecode[i*EW +: EW];
                k_pc    = in_pc[i*DW +: DW];
                k_badv  = in_badv[i*DW +: DW];
            end
            surv[i]     = in_lane_v[i] && !exc_any && !interrupt;
            pend_new[i] = surv[i] && in_we[i] && (in_src[i*2 +: 2] != SRC_ALU);
        end
        if (interrupt) begin
            k_ecode = '0;
            k_pc    = in_pc[DW-1:0];
            k_badv  = '0;
        end
    end

    always_comb begin
        div_hit = 1'b0;
        mem_hit = 1'b0;
        csr_hit = 1'b0;
        clr     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pend_q[i]) begin
                case (src_q[i*2 +: 2])
                    SRC_DIV: if (div_ready && !div_hit) begin
                        clr[i] = 1'b1;
                        div_hit = 1'b1;
                    end
                    SRC_MEM: if (dcache_ready && !mem_hit) begin
                        clr[i] = 1'b1;
                        mem_hit = 1'b1;
                    end
                    SRC_CSR: if (csr_ready && !csr_hit) begin
                        clr[i] = 1'b1;
                        csr_hit = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && pend_new != '0) state_d = WAIT;
                WAIT:    if (pend_d == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = aresetn && (state_q == IDLE) && !flush_in;
        accept   = in_valid && in_ready;
        pend_d   = pend_q;
        commit_d = 1'b0;
        if (flush_in) begin
            pend_d = '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                pend_d   = pend_new;
                commit_d = (pend_new == '0);
            end
        end else begin
            pend_d   = pend_q & ~clr;
            commit_d = (pend_d == '0);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q    <= '0;
            commit_q  <= 1'b0;
            lane_ok_q <= '0;
            we_q      <= '0;
            src_q     <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            exc_q     <= 1'b0;
            ecode_q   <= '0;
            era_q     <= '0;
            badv_q    <= '0;
            badv_we_q <= 1'b0;
            tlbr_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            commit_q <= commit_d;
            if (accept) begin
                lane_ok_q <= surv;
                we_q      <= in_we;
                src_q     <= in_src;
                rd_q      <= in_rd;
                pc_q      <= in_pc;
                data_q    <= in_alu_data;
                exc_q     <= exc_any || interrupt;
                ecode_q   <= k_ecode;
                era_q     <= k_pc;
                badv_q    <= k_badv;
                badv_we_q <= exc_any && !interrupt && needs_badv(k_ecode);
                tlbr_q    <= exc_any && !interrupt && (k_ecode == EC_TLBR);
            end
            for (int i = 0; i < LANES; i++) begin
                if (clr[i]) begin
                    case (src_q[i*2 +: 2])
                        SRC_DIV: data_q[i*DW +: DW] <= div_data;
                        SRC_MEM: data_q[i*DW +: DW] <= dcache_data;
                        default: data_q[i*DW +: DW] <= csr_data;
                    endcase
                end
            end
        end
    end

    always_comb begin
        wb_valid = '0;
        wb_we    = '0;
        wb_rd    = '0;
        wb_data  = '0;
        wb_pc    = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_valid[i] = commit_q && lane_ok_q[i];
            wb_we[i]    = wb_valid[i] && we_q[i];
            if (wb_valid[i]) begin
                wb_rd[i*RW +: RW]   = rd_q[i*RW +: RW];
                wb_data[i*DW +: DW] = data_q[i*DW +: DW];
                wb_pc[i*DW +: DW]   = pc_q[i*DW +: DW];
            end
        end
        exc_valid   = commit_q && exc_q;
        exc_ecode   = exc_valid ? ecode_q : '0;
        exc_era     = exc_valid ? era_q : '0;
        exc_badv    = exc_valid ? badv_q : '0;
        exc_badv_we = exc_valid && badv_we_q;
        exc_tlbr    = exc_valid && tlbr_q;
    end
endmodule

// File: tb/tb_wb_stage_n.sv
// Scoreboard bench for wb_stage_n with two lanes: expected commits are queued
// when a bundle is driven and popped when the commit cycle is sampled.
module tb_wb_stage_n;
    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int EW    = 7;

    logic        clk = 1'b0;
    logic        aresetn, flush_in, in_valid, in_ready, interrupt;
    logic [1:0]  in_lane_v, in_we, in_exc;
    logic [63:0] in_pc, in_alu_data, in_badv;
    logic [9:0]  in_rd;
    logic [3:0]  in_src;
    logic [13:0] in_ecode;
    logic        div_ready, dcache_ready, csr_ready;
    logic [31:0] div_data, dcache_data, csr_data;
    logic [1:0]  wb_valid, wb_we;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data, wb_pc;
    logic        exc_valid, exc_badv_we, exc_tlbr;
    logic [6:0]  exc_ecode;
    logic [31:0] exc_era, exc_badv;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [9:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic        exc;
        logic [6:0]  ecode;
        logic [31:0] era;
        logic [31:0] badv;
        logic        bwe;
        logic        tlbr;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    wb_stage_n #(.LANES(LANES), .DW(DW), .RW(RW), .EW(EW)) dut (
        .clk(clk), .aresetn(aresetn), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_v(in_lane_v),
        .in_pc(in_pc), .in_rd(in_rd), .in_we(in_we), .in_src(in_src),
        .in_alu_data(in_alu_data), .in_exc(in_exc), .in_ecode(in_ecode),
        .in_badv(in_badv), .interrupt(interrupt),
        .div_ready(div_ready), .div_data(div_data),
        .dcache_ready(dcache_ready), .dcache_data(dcache_data),
        .csr_ready(csr_ready), .csr_data(csr_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .exc_valid(exc_valid), .exc_ecode(exc_ecode),
        .exc_era(exc_era), .exc_badv(exc_badv), .exc_badv_we(exc_badv_we),
        .exc_tlbr(exc_tlbr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m32(input logic [1:0] v);
        return {{32{v[1]}}, {32{v[0]}}};
    endfunction

    function automatic logic [9:0] m5(input logic [1:0] v);
        return {{5{v[1]}}, {5{v[0]}}};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 0; in_lane_v = 0; in_pc = 0; in_rd = 0; in_we = 0; in_src = 0;
        in_alu_data = 0; in_exc = 0; in_ecode = 0; in_badv = 0; interrupt = 0;
        flush_in = 0; div_ready = 0; dcache_ready = 0; csr_ready = 0;
        div_data = 0; dcache_data = 0; csr_data = 0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [4:0] rd,
                            input logic we, input logic [1:0] src, input logic [31:0] d);
        in_lane_v[i]          = 1'b1;
        in_pc[i*32 +: 32]       = pc;
        in_rd[i*5 +: 5]         = rd;
        in_we[i]              = we;
        in_src[i*2 +: 2]        = src;
        in_alu_data[i*32 +: 32] = d;
    endtask

    task automatic set_exc(input int i, input logic [6:0] ec, input logic [31:0] bv);
        in_exc[i]           = 1'b1;
        in_ecode[i*7 +: 7]    = ec;
        in_badv[i*32 +: 32]   = bv;
    endtask

    task automatic push(input logic [1:0] v, input logic [1:0] we, input logic [9:0] rd,
                        input logic [63:0] data, input logic [63:0] pc, input logic exc,
                        input logic [6:0] ec, input logic [31:0] era, input logic [31:0] bv,
                        input logic bwe, input logic tl);
        exp_t e;
        e.v = v; e.we = we; e.rd = rd; e.data = data; e.pc = pc; e.exc = exc;
        e.ecode = ec; e.era = era; e.badv = bv; e.bwe = bwe; e.tlbr = tl;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        aresetn = 0;
        clr_in();
        in_valid = 1;
        set_lane(0, 32'h1C000000, 5'd1, 1'b1, 2'd0, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tests++;
        if ({wb_valid, wb_we, exc_valid, wb_data} !== '0) begin
            fails++; $display("FAIL reset_outputs: got v=%b we=%b exc=%b want all 0", wb_valid, wb_we, exc_valid);
        end
        next_cyc();
        aresetn = 1;
        clr_in();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        tests++;
        if ({wb_valid, exc_valid} !== '0) begin
            fails++; $display("FAIL reset_no_accept: got v=%b exc=%b want 0", wb_valid, exc_valid);
        end
    endtask

    task automatic test_alu();
        exp_t e;
        next_cyc(); clr_in();
        set_lane(0, 32'h1C000000, 5'd3, 1'b1, 2'd0, 32'hAA);
        set_lane(1, 32'h1C000004, 5'd4, 1'b1, 2'd0, 32'hBB);
        in_valid = 1;
        push(2'b11, 2'b11, {5'd4, 5'd3}, {32'hBB, 32'hAA}, {32'h1C000004, 32'h1C000000},
             0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || wb_valid !== 2'b00) begin
            fails++; $display("FAIL alu_issue: got ready=%b v=%b want ready=1 v=00", in_ready, wb_valid);
        end
        next_cyc(); clr_in();
        in_valid = 1;
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), wb_pc & m32(e.v)} !== {e.v, e.we, e.rd, e.data, e.pc}) begin
            fails++; $display("FAIL alu_wb: got v=%b we=%b rd=%h data=%h pc=%h want v=%b we=%b rd=%h data=%h pc=%h",
                              wb_valid, wb_we, wb_rd, wb_data, wb_pc, e.v, e.we, e.rd, e.data, e.pc);
        end
        tests++;
        if (exc_valid !== e.exc || in_ready !== 1'b1) begin
            fails++; $display("FAIL alu_exc_ready: got exc=%b ready=%b want exc=0 ready=1", exc_valid, in_ready);
        end
        next_cyc(); clr_in();
        @(negedge clk);
        tests++;
        if ({wb_valid, wb_we, exc_valid, wb_data} !== '0) begin
            fails++; $display("FAIL empty_bundle: got v=%b we=%b exc=%b want all 0", wb_valid, wb_we, exc_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] d0, d1, p;
        logic [1:0]  w;
        for (int n = 0; n <= 4; n++) begin
            next_cyc(); clr_in();
            if (n < 4) begin
                d0 = $urandom; d1 = $urandom; w = 2'($urandom_range(0, 3));
                p  = 32'h1C000100 + 32'(n * 8);
                set_lane(0, p, 5'(n + 1), w[0], 2'd0, d0);
                set_lane(1, p + 4, 5'(n + 10), w[1], 2'd0, d1);
                in_valid = 1;
                push(2'b11, w, {5'(n + 10), 5'(n + 1)}, {d1, d0}, {p + 32'd4, p}, 0, 0, 0, 0, 0, 0);
            end
            @(negedge clk);
            if (n < 4) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready: bundle %0d got %b want 1", n, in_ready);
                end
            end
            if (n > 0) begin
                e = sbq.pop_front();
                tests++;
                if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), wb_pc & m32(e.v), exc_valid} !==
                    {e.v, e.we, e.rd, e.data, e.pc, e.exc}) begin
                    fails++; $display("FAIL b2b_wb: bundle %0d got v=%b we=%b rd=%h data=%h pc=%h want v=%b we=%b rd=%h data=%h pc=%h",
                                      n - 1, wb_valid, wb_we, wb_rd, wb_data, wb_pc, e.v, e.we, e.rd, e.data, e.pc);
                end
            end
        end
    endtask

    task automatic test_div();
        exp_t e;
        next_cyc(); clr_in();
        set_lane(0, 32'h1C000200, 5'd5, 1'b1, 2'd1, 32'hDEAD);
        set_lane(1, 32'h1C000204, 5'd6, 1'b1, 2'd0, 32'h55);
        in_valid = 1;
        push(2'b11, 2'b11, {5'd6, 5'd5}, {32'h55, 32'h7}, {32'h1C000204, 32'h1C000200}, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 5; j++) begin
            next_cyc(); clr_in();
            in_valid = 1;
            set_lane(0, 32'h1C000F00, 5'd9, 1'b1, 2'd0, 32'hF00);
            if (j == 2) begin
                dcache_ready = 1; dcache_data = 32'hBAD; csr_ready = 1; csr_data = 32'hBAD;
            end
            if (j == 5) begin
                div_ready = 1; div_data = 32'h7;
            end
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || wb_valid !== 2'b00) begin
                fails++; $display("FAIL div_wait: cycle %0d got ready=%b v=%b want ready=0 v=00", j, in_ready, wb_valid);
            end
        end
        next_cyc(); clr_in();
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), wb_pc & m32(e.v), exc_valid, in_ready} !==
            {e.v, e.we, e.rd, e.data, e.pc, e.exc, 1'b1}) begin
            fails++; $display("FAIL div_commit: got v=%b rd=%h data=%h pc=%h ready=%b want v=%b rd=%h data=%h pc=%h ready=1",
                              wb_valid, wb_rd, wb_data, wb_pc, in_ready, e.v, e.rd, e.data, e.pc);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if ({wb_valid, exc_valid} !== '0) begin
            fails++; $display("FAIL div_pulse: got v=%b exc=%b want 0", wb_valid, exc_valid);
        end
    endtask

    task automatic test_mem();
        exp_t e;
        next_cyc(); clr_in();
        set_lane(0, 32'h1C000300, 5'd7, 1'b1, 2'd2, 32'h0);
        set_lane(1, 32'h1C000304, 5'd8, 1'b1, 2'd2, 32'h0);
        in_valid = 1;
        push(2'b11, 2'b11, {5'd8, 5'd7}, {32'h22, 32'h11}, {32'h1C000304, 32'h1C000300}, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 3; j++) begin
            next_cyc(); clr_in();
            if (j == 1) begin dcache_ready = 1; dcache_data = 32'h11; end
            if (j == 3) begin dcache_ready = 1; dcache_data = 32'h22; end
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || wb_valid !== 2'b00) begin
                fails++; $display("FAIL mem_wait: cycle %0d got ready=%b v=%b want ready=0 v=00", j, in_ready, wb_valid);
            end
        end
        next_cyc(); clr_in();
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), exc_valid} !== {e.v, e.we, e.rd, e.data, e.exc}) begin
            fails++; $display("FAIL mem_commit: got v=%b rd=%h data=%h want v=%b rd=%h data=%h",
                              wb_valid, wb_rd, wb_data, e.v, e.rd, e.data);
        end
    endtask

    task automatic test_parallel();
        exp_t e;
        next_cyc(); clr_in();
        set_lane(0, 32'h1C000400, 5'd9, 1'b1, 2'd1, 32'h0);
        set_lane(1, 32'h1C000404, 5'd10, 1'b1, 2'd3, 32'h0);
        in_valid = 1;
        push(2'b11, 2'b11, {5'd10, 5'd9}, {32'h99, 32'h77}, {32'h1C000404, 32'h1C000400}, 0, 0, 0, 0, 0, 0);
        next_cyc(); clr_in();
        div_ready = 1; div_data = 32'h77; csr_ready = 1; csr_data = 32'h99;
        dcache_ready = 1; dcache_data = 32'hBAD;
        next_cyc(); clr_in();
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), exc_valid} !== {e.v, e.we, e.rd, e.data, e.exc}) begin
            fails++; $display("FAIL parallel_commit: got v=%b rd=%h data=%h want v=%b rd=%h data=%h",
                              wb_valid, wb_rd, wb_data, e.v, e.rd, e.data);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            next_cyc(); clr_in();
            in_valid = 1;
            case (c)
                0: begin
                    set_lane(0, 32'h1C000500, 5'd11, 1'b1, 2'd0, 32'h123);
                    set_lane(1, 32'h1C000504, 5'd12, 1'b1, 2'd1, 32'h0);
                    set_exc(1, 7'h09, 32'h1003);
                    push(2'b01, 2'b01, {5'd0, 5'd11}, {32'h0, 32'h123}, {32'h0, 32'h1C000500},
                         1, 7'h09, 32'h1C000504, 32'h1003, 1, 0);
                end
                1: begin
                    set_lane(0, 32'h1C000600, 5'd13, 1'b1, 2'd2, 32'h0);
                    set_lane(1, 32'h1C000604, 5'd14, 1'b1, 2'd0, 32'h1);
                    set_exc(0, 7'h3F, 32'h4000);
                    set_exc(1, 7'h0B, 32'h0);
                    push(2'b00, 2'b00, 0, 0, 0, 1, 7'h3F, 32'h1C000600, 32'h4000, 1, 1);
                end
                default: begin
                    set_lane(0, 32'h1C000700, 5'd15, 1'b1, 2'd0, 32'h2);
                    set_exc(0, 7'h0B, 32'h5555);
                    push(2'b00, 2'b00, 0, 0, 0, 1, 7'h0B, 32'h1C000700, 32'h0, 0, 0);
                end
            endcase
            next_cyc(); clr_in();
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if ({wb_valid, wb_we, wb_rd & m5(e.v), wb_data & m32(e.v), wb_pc & m32(e.v)} !== {e.v, e.we, e.rd, e.data, e.pc}) begin
                fails++; $display("FAIL exc_wb: case %0d got v=%b we=%b data=%h want v=%b we=%b data=%h",
                                  c, wb_valid, wb_we, wb_data, e.v, e.we, e.data);
            end
            tests++;
            if (exc_valid !== e.exc || {exc_ecode, exc_era, exc_badv & {32{e.bwe}}, exc_badv_we, exc_tlbr} !==
                {e.ecode, e.era, e.badv, e.bwe, e.tlbr}) begin
                fails++; $display("FAIL exc_info: case %0d got v=%b ec=%h era=%h badv=%h bwe=%b tlbr=%b want v=%b ec=%h era=%h badv=%h bwe=%b tlbr=%b",
                                  c, exc_valid, exc_ecode, exc_era, exc_badv, exc_badv_we, exc_tlbr,
                                  e.exc, e.ecode, e.era, e.badv, e.bwe, e.tlbr);
            end
        end
    endtask

    task automatic test_exc_wait();
        exp_t e;
        next_cyc(); clr_in();
        in_valid = 1;
        set_lane(0, 32'h1C000800, 5'd16, 1'b1, 2'd1, 32'h0);
        set_lane(1, 32'h1C000804, 5'd17, 1'b1, 2'd0, 32'h0);
        set_exc(1, 7'h09, 32'h2001);
        push(2'b01, 2'b01, {5'd0, 5'd16}, {32'h0, 32'h3C}, {32'h0, 32'h1C000800},
             1, 7'h09, 32'h1C000804, 32'h2001, 1, 0);
        for (int j = 1; j <= 2; j++) begin
            next_cyc(); clr_in();
            if (j == 2) begin div_ready = 1; div_data = 32'h3C; end
            @(negedge clk);
            tests++;
            if ({exc_valid, wb_valid} !== '0) begin
                fails++; $display("FAIL exc_early: cycle %0d got exc=%b v=%b want 0", j, exc_valid, wb_valid);
            end
        end
        next_cyc(); clr_in();
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_data & m32(e.v), exc_valid, exc_ecode, exc_era, exc_badv_we} !==
            {e.v, e.data, e.exc, e.ecode, e.era, e.bwe}) begin
            fails++; $display("FAIL exc_wait_commit: got v=%b data=%h exc=%b ec=%h era=%h want v=%b data=%h exc=%b ec=%h era=%h",
                              wb_valid, wb_data, exc_valid, exc_ecode, exc_era, e.v, e.data, e.exc, e.ecode, e.era);
        end
    endtask

    task automatic test_interrupt();
        exp_t e;
        next_cyc(); clr_in();
        in_valid = 1; interrupt = 1;
        set_lane(0, 32'h1C000900, 5'd18, 1'b1, 2'd0, 32'h5);
        set_lane(1, 32'h1C000904, 5'd19, 1'b1, 2'd1, 32'h6);
        push(2'b00, 2'b00, 0, 0, 0, 1, 7'h00, 32'h1C000900, 32'h0, 0, 0);
        next_cyc(); clr_in();
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if ({wb_valid, wb_we, exc_valid, exc_ecode, exc_era, exc_badv_we, exc_tlbr} !==
            {e.v, e.we, e.exc, e.ecode, e.era, e.bwe, e.tlbr}) begin
            fails++; $display("FAIL interrupt: got v=%b exc=%b ec=%h era=%h bwe=%b want v=%b exc=%b ec=%h era=%h bwe=%b",
                              wb_valid, exc_valid, exc_ecode, exc_era, exc_badv_we, e.v, e.exc, e.ecode, e.era, e.bwe);
        end
        next_cyc();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || exc_valid !== 1'b0) begin
            fails++; $display("FAIL interrupt_idle: got ready=%b exc=%b want ready=1 exc=0", in_ready, exc_valid);
        end
    endtask

    task automatic test_flush();
        next_cyc(); clr_in();
        in_valid = 1;
        set_lane(0, 32'h1C000A00, 5'd20, 1'b1, 2'd1, 32'h0);
        next_cyc(); clr_in();
        flush_in = 1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_ready_low: got %b want 0", in_ready);
        end
        next_cyc(); clr_in();
        div_ready = 1; div_data = 32'h9;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || wb_valid !== 2'b00) begin
            fails++; $display("FAIL flush_ready_back: got ready=%b v=%b want ready=1 v=00", in_ready, wb_valid);
        end
        next_cyc(); clr_in();
        in_valid = 1; flush_in = 1;
        set_lane(0, 32'h1C000B00, 5'd21, 1'b1, 2'd0, 32'h1);
        @(negedge clk);
        tests++;
        if ({wb_valid, exc_valid, in_ready} !== '0) begin
            fails++; $display("FAIL flush_stale_strobe: got v=%b exc=%b ready=%b want 0", wb_valid, exc_valid, in_ready);
        end
        next_cyc(); clr_in();
        in_valid = 1;
        set_lane(0, 32'h1C000C00, 5'd22, 1'b1, 2'd1, 32'h0);
        @(negedge clk);
        tests++;
        if (wb_valid !== 2'b00) begin
            fails++; $display("FAIL flush_block_accept: got v=%b want 00", wb_valid);
        end
        next_cyc(); clr_in();
        div_ready = 1; div_data = 32'hA; flush_in = 1;
        next_cyc(); clr_in();
        @(negedge clk);
        tests++;
        if ({wb_valid, exc_valid} !== '0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_suppress: got v=%b exc=%b ready=%b want v=00 exc=0 ready=1", wb_valid, exc_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        next_cyc(); clr_in();
        in_valid = 1;
        set_lane(0, 32'h1C000D00, 5'd23, 1'b1, 2'd0, 32'h42);
        set_lane(1, 32'h1C000D04, 5'd24, 1'b1, 2'd0, 32'h43);
        next_cyc(); clr_in();
        @(negedge clk);
        tests++;
        if (wb_valid !== 2'b11) begin
            fails++; $display("FAIL rst_pre_commit: got v=%b want 11", wb_valid);
        end
        #1 aresetn = 0;
        #1;
        tests++;
        if ({wb_valid, wb_we, exc_valid, wb_data, in_ready} !== '0) begin
            fails++; $display("FAIL rst_async_commit: got v=%b data=%h ready=%b want 0", wb_valid, wb_data, in_ready);
        end
        next_cyc(); aresetn = 1;
        in_valid = 1;
        set_lane(0, 32'h1C000E00, 5'd25, 1'b1, 2'd1, 32'h0);
        next_cyc(); clr_in();
        @(negedge clk);
        #1 aresetn = 0;
        #1;
        tests++;
        if ({wb_valid, exc_valid, in_ready} !== '0) begin
            fails++; $display("FAIL rst_mid_wait: got v=%b exc=%b ready=%b want 0", wb_valid, exc_valid, in_ready);
        end
        next_cyc(); aresetn = 1;
        div_ready = 1; div_data = 32'h3;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_ready_back: got %b want 1", in_ready);
        end
        next_cyc(); clr_in();
        @(negedge clk);
        tests++;
        if ({wb_valid, exc_valid} !== '0) begin
            fails++; $display("FAIL rst_no_commit: got v=%b exc=%b want 0", wb_valid, exc_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_div();
        test_mem();
        test_parallel();
        test_exception();
        test_exc_wait();
        test_interrupt();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
